// File: rtl/cache_pkg.sv
// Shared cache/memory constants and the refill arbiter state encoding.
package cache_pkg;
  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int BLK_WORDS_DEF   = 8;   // 16-bit words per 16-byte block
  localparam int MEM_LATENCY_DEF = 4;   // mem_en to mem_data_valid
  localparam int OFF_W           = 4;   // byte offset bits inside a block
  localparam int CNT_W           = 3;   // word index within a block

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FILL_I = 2'd2,
    FILL_D = 2'd3
  } state_e;
endpackage

// File: rtl/word_counter.sv
// Word index counter: synchronous clear has priority over increment; wraps naturally.
module word_counter
  import cache_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  // Count enabled beats, clear on a fresh grant.
  always_ff @(posedge clk) begin
    if (!rst_n)     cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + W'(1);
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates write-through stores and I/D block refills onto one memory port.
module mem_arbiter
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int BLK_WORDS   = BLK_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss_req,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss_req,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid,
  output logic              fill_we_i,
  output logic              fill_we_d,
  output logic [CNT_W-1:0]  fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLK_WORDS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                issue_done_q, issue_done_d;
  // One bit per read in flight; the top bit marks the cycle its data is due.
  // Beats with no matching issue (stale after reset, spurious) are dropped.
  logic [MEM_LATENCY-1:0] iss_pipe_q, iss_pipe_d;
  logic                cnt_clr, issue_en, recv_en, beat_ok;
  logic [CNT_W-1:0]    issue_cnt, recv_cnt;

  word_counter #(.W(CNT_W)) u_issue_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .en_i(issue_en), .cnt_o(issue_cnt)
  );
  word_counter #(.W(CNT_W)) u_recv_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .en_i(recv_en), .cnt_o(recv_cnt)
  );

  assign beat_ok    = mem_data_valid && iss_pipe_q[MEM_LATENCY-1];
  assign iss_pipe_d = (iss_pipe_q << 1) | MEM_LATENCY'(issue_en);

  // State, latched request and in-flight tracking registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      issue_done_q <= 1'b0;
      iss_pipe_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      issue_done_q <= issue_done_d;
      iss_pipe_q   <= iss_pipe_d;
    end
  end

  // Next state, grant and memory/fill outputs; everything is forced low in reset.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    issue_done_d = issue_done_q;
    cnt_clr      = 1'b0;
    issue_en     = 1'b0;
    recv_en      = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_we_i    = 1'b0;
    fill_we_d    = 1'b0;
    fill_idx     = '0;
    fill_data    = '0;
    i_fill_done  = 1'b0;
    d_fill_done  = 1'b0;
    d_wr_ack     = 1'b0;
    busy         = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (d_wr_req || d_miss_req || i_miss_req) begin
          cnt_clr      = 1'b1;
          issue_done_d = 1'b0;
        end
        if (d_wr_req) begin
          state_d = WRITE;
          addr_d  = d_wr_addr;
          wdata_d = d_wr_data;
        end else if (d_miss_req) begin
          state_d = FILL_D;
          addr_d  = d_miss_addr;
        end else if (i_miss_req) begin
          state_d = FILL_I;
          addr_d  = i_miss_addr;
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        d_wr_ack  = 1'b1;
        state_d   = IDLE;
      end
      FILL_I, FILL_D: begin
        if (!issue_done_q) begin
          mem_en   = 1'b1;
          mem_addr = {addr_q[ADDR_W-1:OFF_W], issue_cnt, 1'b0};
          issue_en = 1'b1;
          if (issue_cnt == LAST) issue_done_d = 1'b1;
        end
        if (beat_ok) begin
          recv_en   = 1'b1;
          fill_we_i = (state_q == FILL_I);
          fill_we_d = (state_q == FILL_D);
          fill_idx  = recv_cnt;
          fill_data = mem_rdata;
          if (recv_cnt == LAST) begin
            i_fill_done = (state_q == FILL_I);
            d_fill_done = (state_q == FILL_D);
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      issue_en    = 1'b0;
      recv_en     = 1'b0;
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      fill_we_i   = 1'b0;
      fill_we_d   = 1'b0;
      fill_idx    = '0;
      fill_data   = '0;
      i_fill_done = 1'b0;
      d_fill_done = 1'b0;
      d_wr_ack    = 1'b0;
      busy        = 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: latency-accurate memory model plus scoreboards of
// expected memory accesses, cache fill writes and completion pulses.
module tb_mem_arbiter;
  localparam int LAT = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_miss_req = 1'b0, d_miss_req = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic        mem_en, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        fill_we_i, fill_we_d, i_fill_done, d_fill_done, d_wr_ack, busy;
  logic [2:0]  fill_idx;
  logic [15:0] fill_data;

  int checks = 0, failures = 0, cyc = 0;

  typedef struct { logic wr; logic [15:0] addr; logic [15:0] data; int cyc; } mem_t;
  typedef struct { logic side; logic [2:0] idx; logic [15:0] data; int cyc; } fill_t;
  typedef struct { int kind; int cyc; } evt_t;   // 0 i_done, 1 d_done, 2 wr_ack
  mem_t  exp_mem[$];
  fill_t exp_fill[$];
  evt_t  exp_evt[$];

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
    .fill_we_i(fill_we_i), .fill_we_d(fill_we_d), .fill_idx(fill_idx), .fill_data(fill_data),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_ack(d_wr_ack), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: a read issued in cycle c returns addr^5A5A in cycle c+LAT.
  logic        iss_n = 1'b0, spur = 1'b0;
  logic [15:0] adr_n = '0;
  logic        p_v[LAT];
  logic [15:0] p_a[LAT];
  initial for (int i = 0; i < LAT; i++) begin p_v[i] = 1'b0; p_a[i] = '0; end
  always @(negedge clk) begin
    iss_n <= mem_en && !mem_wr;
    adr_n <= mem_addr;
  end
  always @(posedge clk) begin
    p_v[0] <= iss_n;
    p_a[0] <= adr_n;
    for (int i = 1; i < LAT; i++) begin p_v[i] <= p_v[i-1]; p_a[i] <= p_a[i-1]; end
  end
  assign mem_data_valid = p_v[LAT-1] | spur;
  assign mem_rdata      = p_a[LAT-1] ^ 16'h5A5A;

  // Output monitor: every memory access, fill write and pulse pops its scoreboard.
  always @(negedge clk) begin
    mem_t m; fill_t f; evt_t e;
    if (mem_en) begin
      checks++;
      if (exp_mem.size() == 0) begin
        failures++;
        $display("FAIL mem_unexpected cyc=%0d wr=%b addr=%h", cyc, mem_wr, mem_addr);
      end else begin
        m = exp_mem.pop_front();
        if (mem_wr !== m.wr || mem_addr !== m.addr || cyc != m.cyc ||
            (m.wr && mem_wdata !== m.data)) begin
          failures++;
          $display("FAIL mem_access got cyc=%0d wr=%b addr=%h wdata=%h exp cyc=%0d wr=%b addr=%h wdata=%h",
                   cyc, mem_wr, mem_addr, mem_wdata, m.cyc, m.wr, m.addr, m.data);
        end
      end
    end
    if (fill_we_i || fill_we_d) begin
      checks++;
      if (exp_fill.size() == 0 || (fill_we_i && fill_we_d)) begin
        failures++;
        $display("FAIL fill_unexpected cyc=%0d we_i=%b we_d=%b idx=%0d", cyc, fill_we_i, fill_we_d, fill_idx);
      end else begin
        f = exp_fill.pop_front();
        if (fill_we_d !== f.side || fill_idx !== f.idx || fill_data !== f.data || cyc != f.cyc) begin
          failures++;
          $display("FAIL fill_write got cyc=%0d d=%b idx=%0d data=%h exp cyc=%0d d=%b idx=%0d data=%h",
                   cyc, fill_we_d, fill_idx, fill_data, f.cyc, f.side, f.idx, f.data);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if ((k == 0 && i_fill_done) || (k == 1 && d_fill_done) || (k == 2 && d_wr_ack)) begin
        checks++;
        if (exp_evt.size() == 0) begin
          failures++;
          $display("FAIL pulse_unexpected cyc=%0d kind=%0d", cyc, k);
        end else begin
          e = exp_evt.pop_front();
          if (e.kind != k || e.cyc != cyc) begin
            failures++;
            $display("FAIL pulse got kind=%0d cyc=%0d exp kind=%0d cyc=%0d", k, cyc, e.kind, e.cyc);
          end
        end
      end
    end
  end

  // Queue the expected reads/fills/done for a fill granted in cycle t.
  task automatic push_fill(input logic side, input int t, input logic [15:0] a,
                           input int n_mem, input int n_fill, input bit done);
    logic [15:0] wa;
    for (int k = 0; k < n_mem; k++) begin
      wa = {a[15:4], 3'(k), 1'b0};
      exp_mem.push_back('{1'b0, wa, 16'h0, t + 1 + k});
    end
    for (int k = 0; k < n_fill; k++) begin
      wa = {a[15:4], 3'(k), 1'b0};
      exp_fill.push_back('{side, 3'(k), wa ^ 16'h5A5A, t + 1 + LAT + k});
    end
    if (done) exp_evt.push_back('{side ? 1 : 0, t + 8 + LAT});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic start(output int t);
    @(posedge clk); #1; t = cyc;
  endtask

  task automatic test_reset();
    i_miss_req = 1'b1; i_miss_addr = 16'h1111;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({busy, mem_en, fill_we_i, fill_we_d, i_fill_done, d_fill_done, d_wr_ack} !== 7'b0) begin
      failures++; $display("FAIL reset_outputs got %b exp 0", {busy, mem_en, fill_we_i, fill_we_d});
    end
    i_miss_req = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, mem_addr, mem_wdata, fill_idx, fill_data} !== 52'b0) begin
      failures++; $display("FAIL idle_outputs got busy=%b addr=%h wdata=%h", busy, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_i_fill();
    int t;
    start(t);
    i_miss_req = 1'b1; i_miss_addr = 16'h1236;
    push_fill(1'b0, t, 16'h1236, 8, 8, 1);
    wait_until(t + 1);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL ifill_busy got %b exp 1", busy); end
    wait_until(t + 13);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ifill_idle got %b exp 0", busy); end
    i_miss_req = 1'b0;
  endtask

  task automatic test_priority();
    int t;
    start(t);
    d_miss_req = 1'b1; d_miss_addr = 16'h2000;
    i_miss_req = 1'b1; i_miss_addr = 16'h3458;
    push_fill(1'b1, t, 16'h2000, 8, 8, 1);
    push_fill(1'b0, t + 13, 16'h3458, 8, 8, 1);
    wait_until(t + 13);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL prio_gap got %b exp 0", busy); end
    d_miss_req = 1'b0;
    wait_until(t + 14);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL prio_igrant got %b exp 1", busy); end
    wait_until(t + 26);
    i_miss_req = 1'b0;
  endtask

  task automatic test_write();
    int t;
    start(t);
    d_wr_req = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    d_miss_req = 1'b1; d_miss_addr = 16'h0088;
    exp_mem.push_back('{1'b1, 16'h0040, 16'hBEEF, t + 1});
    exp_evt.push_back('{2, t + 1});
    push_fill(1'b1, t + 2, 16'h0088, 8, 8, 1);
    wait_until(t + 2);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL write_idle got %b exp 0", busy); end
    d_wr_req = 1'b0;
    wait_until(t + 15);
    d_miss_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t;
    start(t);
    i_miss_req = 1'b1; i_miss_addr = 16'h4440;
    push_fill(1'b0, t, 16'h4440, 5, 1, 0);
    wait_until(t + 6);
    rst_n = 1'b0; i_miss_req = 1'b0;
    wait_until(t + 7);
    rst_n = 1'b1;
    checks++;
    if ({busy, fill_we_i} !== 2'b0) begin
      failures++; $display("FAIL rstmid_abort got busy=%b we_i=%b exp 0", busy, fill_we_i);
    end
    i_miss_req = 1'b1; i_miss_addr = 16'h5550;
    push_fill(1'b0, t + 7, 16'h5550, 8, 8, 1);
    wait_until(t + 20);
    i_miss_req = 1'b0;
  endtask

  task automatic test_spurious();
    int t;
    start(t);
    spur = 1'b1;
    #1;
    checks++;
    if ({fill_we_i, fill_we_d, busy} !== 3'b0) begin
      failures++; $display("FAIL spurious_we got %b exp 0", {fill_we_i, fill_we_d, busy});
    end
    wait_until(t + 3);
    spur = 1'b0;
    i_miss_req = 1'b1; i_miss_addr = 16'h6660;
    push_fill(1'b0, t + 3, 16'h6660, 8, 8, 1);
    wait_until(t + 16);
    i_miss_req = 1'b0;
  endtask

  task automatic test_drop();
    int t;
    start(t);
    i_miss_req = 1'b1; i_miss_addr = 16'h7772;
    push_fill(1'b0, t, 16'h7772, 8, 8, 1);
    wait_until(t + 3);
    i_miss_req = 1'b0;
    wait_until(t + 13);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL drop_idle got %b exp 0", busy); end
  endtask

  task automatic test_drain();
    repeat (10) @(posedge clk); #1;
    checks++;
    if (exp_mem.size() != 0 || exp_fill.size() != 0 || exp_evt.size() != 0) begin
      failures++;
      $display("FAIL drain_left mem=%0d fill=%0d evt=%0d exp 0", exp_mem.size(), exp_fill.size(), exp_evt.size());
    end
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_priority();
    test_write();
    test_reset_mid();
    test_spurious();
    test_drop();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
